// File: rtl/ext_trg_pkg.sv
// ext_trg_pkg
// Shared definitions for the external trigger path (input conditioner and
// output driver): FSM state encoding, default counter widths, pin polarity
// constants and the trigger edge-type encoding used by the receiver.
package ext_trg_pkg;

   // Default widths of the delay/width/period counters and pulse count.
   localparam int CNT_W = 32;
   localparam int NUM_W = 16;

   // Pin polarity: level driven while a pulse is active is ~polarity.
   localparam logic POL_HIGH = 1'b0;  // active-high pin
   localparam logic POL_LOW  = 1'b1;  // active-low pin

   // Output driver states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_GAP    = 2'd3
   } ext_trg_state_t;

   // Receiver edge selection, kept here so both ends share one encoding.
   typedef enum logic [1:0] {
      TRG_RISING  = 2'b00,
      TRG_FALLING = 2'b01,
      TRG_BOTH    = 2'b10
   } ext_trg_type_t;

endpackage

// File: rtl/ext_trg_drv.sv
// ext_trg_drv
// Programmable external trigger output generator. A single-cycle trg_in
// (accepted only in IDLE while enabled and not aborted) launches a burst of
// N pulses: D cycles of delay, then pulses of W active cycles repeating every
// Pe cycles. The pin is a flop output, ready for the IOB register.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   trg_in               single-cycle trigger request
//   ctrl_enable          arm; low ignores trg_in and aborts a burst
//   ctrl_polarity        0 = active-high pin, 1 = active-low pin
//   ctrl_delay/width/period/count  burst shape, latched at acceptance
//   ctrl_abort           level; forces return to IDLE
//   ext_trg_out          registered pin drive
//   busy                 burst in progress (state != IDLE)
//   done                 one-cycle strobe on the first cycle after a burst
//   missed               one-cycle strobe: trg_in arrived while busy
module ext_trg_drv #(
   parameter int CNT_W = ext_trg_pkg::CNT_W,
   parameter int NUM_W = ext_trg_pkg::NUM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trg_in,
   input  logic             ctrl_enable,
   input  logic             ctrl_polarity,
   input  logic [CNT_W-1:0] ctrl_delay,
   input  logic [CNT_W-1:0] ctrl_width,
   input  logic [CNT_W-1:0] ctrl_period,
   input  logic [NUM_W-1:0] ctrl_count,
   input  logic             ctrl_abort,
   output logic             ext_trg_out,
   output logic             busy,
   output logic             done,
   output logic             missed
);
   import ext_trg_pkg::*;

   ext_trg_state_t   state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;      // shared phase counter
   logic [CNT_W-1:0] width_reg, width_next;  // effective W
   logic [CNT_W-1:0] gap_reg, gap_next;      // Pe - W, at least 1
   logic [NUM_W-1:0] num_reg, num_next;      // pulses remaining incl. current
   logic             pol_reg, pol_next;
   logic             out_reg, out_next;
   logic             done_reg, done_next;
   logic             missed_reg, missed_next;

   logic [CNT_W-1:0] w_eff, w_plus1, pe_eff, gap_eff;
   logic [NUM_W-1:0] n_eff;
   logic             abort_req;

   // Effective burst parameters from the live control inputs.
   always_comb begin
      w_eff   = (ctrl_width == '0) ? CNT_W'(1) : ctrl_width;
      // W+1 saturates so the max() below cannot wrap for W = all-ones.
      w_plus1 = (&w_eff) ? w_eff : w_eff + CNT_W'(1);
      pe_eff  = (ctrl_period > w_plus1) ? ctrl_period : w_plus1;
      gap_eff = pe_eff - w_eff;
      if (gap_eff == '0)
         gap_eff = CNT_W'(1);
      n_eff   = (ctrl_count == '0) ? NUM_W'(1) : ctrl_count;
   end

   assign abort_req = ctrl_abort || !ctrl_enable;

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      width_next  = width_reg;
      gap_next    = gap_reg;
      num_next    = num_reg;
      pol_next    = pol_reg;
      done_next   = 1'b0;
      missed_next = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            pol_next = ctrl_polarity;
            if (trg_in && !abort_req) begin
               width_next = w_eff;
               gap_next   = gap_eff;
               num_next   = n_eff;
               if (ctrl_delay != '0) begin
                  state_next = ST_DELAY;
                  cnt_next   = ctrl_delay - CNT_W'(1);
               end else begin
                  state_next = ST_ACTIVE;
                  cnt_next   = w_eff - CNT_W'(1);
               end
            end
         end
         ST_DELAY, ST_GAP: begin
            if (cnt_reg == '0) begin
               state_next = ST_ACTIVE;
               cnt_next   = width_reg - CNT_W'(1);
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_ACTIVE: begin
            if (cnt_reg == '0) begin
               if (num_reg <= NUM_W'(1)) begin
                  state_next = ST_IDLE;
                  num_next   = '0;
                  done_next  = 1'b1;
               end else begin
                  state_next = ST_GAP;
                  num_next   = num_reg - NUM_W'(1);
                  cnt_next   = gap_reg - CNT_W'(1);
               end
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (state_reg != ST_IDLE) begin
         missed_next = trg_in;
         // Abort wins over everything, including the final ACTIVE cycle.
         if (abort_req) begin
            state_next  = ST_IDLE;
            cnt_next    = '0;
            num_next    = '0;
            done_next   = 1'b0;
            missed_next = 1'b0;
         end
      end

      // Pin follows the next state so it lines up with state_reg; in IDLE
      // the inactive level tracks the live polarity input.
      if (state_next == ST_IDLE)
         out_next = ctrl_polarity;
      else if (state_next == ST_ACTIVE)
         out_next = ~pol_next;
      else
         out_next = pol_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         width_reg  <= '0;
         gap_reg    <= '0;
         num_reg    <= '0;
         pol_reg    <= 1'b0;
         out_reg    <= 1'b0;
         done_reg   <= 1'b0;
         missed_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         width_reg  <= width_next;
         gap_reg    <= gap_next;
         num_reg    <= num_next;
         pol_reg    <= pol_next;
         out_reg    <= out_next;
         done_reg   <= done_next;
         missed_reg <= missed_next;
      end
   end

   assign ext_trg_out = out_reg;
   assign busy        = (state_reg != ST_IDLE);
   assign done        = done_reg;
   assign missed      = missed_reg;

endmodule

// File: doc/ext_trg_drv.md
# ext_trg_drv

Programmable external trigger output generator: the transmit-side counterpart of the external trigger input conditioner. On a single-cycle internal request (PTP time-compare match, software strobe), it drives a burst of pulses onto the external trigger pin. Delay, width, period, pulse count and pin polarity are all programmable. It sits between the timing core and the output pad (IOB register), in the same clock domain as the timing core.

## Interface
- CNT_W, 32, width of the delay/width/period counters
- NUM_W, 16, width of the pulse-count field

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- trg_in  in  1  single-cycle trigger request
- ctrl_enable  in  1  1 = block armed; 0 = trg_in ignored and any burst aborted
- ctrl_polarity  in  1  0 = active-high pin, 1 = active-low pin
- ctrl_delay  in  CNT_W  cycles from acceptance to first pulse edge
- ctrl_width  in  CNT_W  active cycles per pulse; 0 treated as 1
- ctrl_period  in  CNT_W  cycles between pulse starts; effective Pe = max(ctrl_period, W+1)
- ctrl_count  in  NUM_W  pulses per trigger; 0 treated as 1
- ctrl_abort  in  1  level; forces return to IDLE
- ext_trg_out  out  1  registered pin drive, pad-ready
- busy  out  1  high while a burst is in progress (state != IDLE)
- done  out  1  one-cycle strobe after the last pulse of a completed burst
- missed  out  1  one-cycle strobe when trg_in arrives while busy

## Operation
- States: IDLE, DELAY, ACTIVE, GAP. All counters are down-counters and saturate at 0.
- IDLE: trg_in=1, ctrl_enable=1 and ctrl_abort=0 accept the trigger.
  - On acceptance, latch delay, W, Pe, N and polarity.
  - Go to DELAY if D>0, else go to ACTIVE.
- DELAY: hold for D cycles, then go to ACTIVE.
- ACTIVE: hold for W cycles and decrement the remaining pulse count. Then:
  - If pulses remain, go to GAP.
  - Otherwise go to IDLE and assert done.
- GAP: hold for Pe−W cycles, then go to ACTIVE.
- Pin level = (state==ACTIVE) XOR polarity.
  - Polarity is live in IDLE and latched while busy.
  - Changing ctrl_* while busy has no effect on the current burst.
- trg_in while busy (including the final ACTIVE cycle): no retrigger; missed=1 for one cycle.
- trg_in while ctrl_enable=0: ignored; missed stays 0.
- Abort: ctrl_abort=1 or ctrl_enable=0 in any non-IDLE state gives the following next cycle:
  - state IDLE, pin inactive;
  - done=0, missed=0.
- trg_in coincident with abort in IDLE is not accepted.
- Arithmetic: Pe−W is computed once at latch, in CNT_W bits. Pe ≥ W+1 guarantees a GAP length ≥ 1. For W = 2^CNT_W−1, Pe saturates at all-ones and GAP = 1.

## Timing
- Reset values: ext_trg_out=0, busy=0, done=0, missed=0, state=IDLE. From the first cycle after reset, ext_trg_out = ctrl_polarity.
- Trigger accepted at cycle T:
  - busy=1 from T+1.
  - Pulse k (k=0..N−1) is active on cycles T+1+D+k·Pe through T+D+k·Pe+W inclusive.
- Completion after the last pulse:
  - On the first inactive cycle, done=1 and busy=0.
  - In that same cycle the block is in IDLE, so a new trg_in is accepted back-to-back.
- missed is registered: it asserts the cycle after the offending trg_in.
- ext_trg_out is a flop output with no combinational path from any input. Its latency from trg_in is exactly 1+D cycles.

## Structure
- Package ext_trg_pkg holds:
  - the state enum typedef ext_trg_state_t;
  - default widths CNT_W=32 and NUM_W=16;
  - the polarity constants POL_HIGH/POL_LOW.
- The receiver's trigger-type encoding (00 rising, 01 falling, 10 both) moves into the same package so both ends share one definition.
- Single module, no sub-module. One shared phase counter is reloaded per state plus one pulse counter; separate per-state counters are not used.

## Test plan
- D=0, W=1, P=0, N=1, pol=0: trg_in at T → ext_trg_out=1 only at T+1; done at T+2; busy high T+1 only.
- D=5, W=3, P=10, N=3, pol=0: pulses active on T+6..T+8, T+16..T+18, T+26..T+28; done at T+29.
- pol=1, D=2, W=4, N=1: pin idles high; low on T+3..T+6; high again from T+7.
- trg_in every cycle during a burst (D=0, W=4, P=8, N=2): missed pulses for each in-burst trigger; trigger on the done cycle is accepted and starts a new pulse next cycle.
- ctrl_abort at the 2nd cycle of pulse 2 (W=5, N=4): pin inactive next cycle, busy=0, done never asserts; rst mid-burst gives the same outputs plus all outputs 0.
- Corner cases: W=0, N=0, P<W (W=6, P=2) → behaves as W=1/N=1 and Pe=7; ctrl_enable=0 with trg_in → no activity, missed=0.
